// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store path.
// Data wins ties, except when IF has waited through MAX_D_STREAK data grants.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          if_stall,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t        state, state_nx;
  logic [3:0]    streak, streak_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          req_nx, we_nx, if_ack_nx, d_ack_nx, err_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx, if_rdata_nx, d_rdata_nx;
  logic          grant_if, grant_d, tmo_hit;

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;
  assign tmo_hit  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx    = state;
    streak_nx   = streak;
    tcnt_nx     = tcnt;
    req_nx      = mem_req;
    we_nx       = mem_we;
    addr_nx     = mem_addr;
    wdata_nx    = mem_wdata;
    if_rdata_nx = if_rdata;
    d_rdata_nx  = d_rdata;
    if_ack_nx   = 1'b0;
    d_ack_nx    = 1'b0;
    err_nx      = 1'b0;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    case (state)
      IDLE: begin
        grant_if = if_req && (!d_req || streak == 4'(MAX_D_STREAK));
        grant_d  = d_req && !grant_if;
        if (grant_if) begin
          state_nx  = BUSY_IF;
          streak_nx = '0;
          we_nx     = 1'b0;
          addr_nx   = if_addr;
          wdata_nx  = '0;
        end else if (grant_d) begin
          state_nx  = BUSY_D;
          // streak only grows while fetch is actually waiting
          if (!if_req)                          streak_nx = '0;
          else if (streak != 4'(MAX_D_STREAK))  streak_nx = streak + 4'd1;
          we_nx     = d_we;
          addr_nx   = d_addr;
          wdata_nx  = d_wdata;
        end
        if (grant_if || grant_d) begin
          req_nx  = 1'b1;
          tcnt_nx = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack) begin
          req_nx   = 1'b0;
          state_nx = IDLE;
          if (state == BUSY_IF) begin
            if_ack_nx   = 1'b1;
            if_rdata_nx = mem_rdata;
          end else begin
            d_ack_nx   = 1'b1;
            d_rdata_nx = mem_we ? '0 : mem_rdata;
          end
        end else begin
          tcnt_nx = tcnt + TW'(1);
          if (tmo_hit) begin
            req_nx   = 1'b0;
            err_nx   = 1'b1;
            state_nx = IDLE;
            if (state == BUSY_IF) begin
              if_ack_nx   = 1'b1;
              if_rdata_nx = '0;
            end else begin
              d_ack_nx   = 1'b1;
              d_rdata_nx = '0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      streak    <= streak_nx;
      tcnt      <= tcnt_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      if_ack    <= if_ack_nx;
      d_ack     <= d_ack_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      err       <= err_nx;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level model of grants,
// memory wait states, timeouts and acks, plus directed streak and reset cases.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4, TO = 8;

  logic          clk = 1'b0, reset;
  logic          if_req, if_ack, d_req, d_we, d_ack, err, if_stall, d_stall;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one outstanding access, described by its wait count
  bit            busy, who_if, tmo, hold_phase;
  int            k, w, kack, streak, d_run, if_grants_hold;
  logic [AW-1:0] c_addr;
  logic          c_we;
  logic [DW-1:0] c_wd;
  int            p_raise_if, p_raise_d, p_keep;

  // called at each negedge: advance model over the last posedge, check, drive next inputs
  task automatic step();
    bit            ack_ev = 1'b0, gif;
    logic [DW-1:0] exp_rd = '0;
    if (busy) begin
      k++;
      if (k == kack) begin
        ack_ev = 1'b1;
        exp_rd = (tmo || c_we) ? '0 : mem_rdata;
        busy   = 1'b0;
      end
    end else if (if_req || d_req) begin
      gif = if_req && (!d_req || streak == MAXS);
      if (gif) streak = 0;
      else     streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
      if (hold_phase) begin
        if (gif) begin
          if (if_grants_hold > 0) chk("d_run", d_run, MAXS);
          if_grants_hold++;
          d_run = 0;
        end else d_run++;
      end
      who_if = gif;
      c_addr = gif ? if_addr : d_addr;
      c_we   = gif ? 1'b0 : d_we;
      c_wd   = gif ? '0 : d_wdata;
      busy   = 1'b1;
      k      = 0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: w = 0;
        4, 5:       w = 1;
        6:          w = 2;
        7:          w = 3;
        8:          w = TO - 1;
        default:    w = 50;
      endcase
      tmo  = (w >= TO);
      kack = tmo ? TO : w + 1;
    end

    chk("mem_req", mem_req, busy);
    if (busy) begin
      chk("mem_addr", mem_addr, c_addr);
      chk("mem_we", mem_we, c_we);
      chk("mem_wdata", mem_wdata, c_wd);
    end
    chk("if_ack", if_ack, ack_ev && who_if);
    chk("d_ack", d_ack, ack_ev && !who_if);
    chk("err", err, ack_ev && tmo);
    if (ack_ev) begin
      if (who_if) chk("if_rdata", if_rdata, exp_rd);
      else        chk("d_rdata", d_rdata, exp_rd);
    end
    chk("if_stall", if_stall, if_req && !(ack_ev && who_if));
    chk("d_stall", d_stall, d_req && !(ack_ev && !who_if));

    mem_ack   = busy ? (k == w) : ($urandom_range(0, 7) == 0);
    mem_rdata = $urandom;
    if (if_req) begin
      if (ack_ev && who_if) begin
        if ($urandom_range(0, 99) < p_keep) if_addr = if_addr + 32'd4;
        else                                 if_req  = 1'b0;
      end
    end else if ($urandom_range(0, 99) < p_raise_if) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req) begin
      if (ack_ev && !who_if) begin
        if ($urandom_range(0, 99) < p_keep) begin
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
        end else d_req = 1'b0;
      end
    end else if ($urandom_range(0, 99) < p_raise_d) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    busy = 1'b0; who_if = 1'b0; tmo = 1'b0; streak = 0; k = 0; w = 0; kack = 0;
    c_addr = '0; c_we = 1'b0; c_wd = '0;
    hold_phase = 1'b0; d_run = 0; if_grants_hold = 0;

    #12;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_if_ack", if_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_if_rdata", if_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    if_req = 1'b1;
    #1;
    chk("rst_if_stall", if_stall, 1'b1);
    chk("rst_d_stall", d_stall, 1'b0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // mixed random traffic
    p_raise_if = 30; p_raise_d = 30; p_keep = 50;
    run(1200);

    // both requesters held continuously: D run length between IF grants
    p_raise_if = 100; p_raise_d = 100; p_keep = 100;
    hold_phase = 1'b1;
    run(300);
    hold_phase = 1'b0;
    chk("hold_if_grants", if_grants_hold >= 3, 1'b1);

    // back-to-back fetch with stepping address
    p_raise_d = 0; p_keep = 0;
    run(40);
    p_raise_if = 100; p_keep = 100;
    run(100);

    // reset in the middle of a data access
    p_raise_if = 0; p_raise_d = 100; p_keep = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      step();
      if (busy && !who_if) found = 1'b1;
    end
    chk("rst_mid_found", found, 1'b1);
    if (found) begin
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_mem_req", mem_req, 1'b0);
      chk("rst_mid_d_ack", d_ack, 1'b0);
      chk("rst_mid_err", err, 1'b0);
      d_req = 1'b0; if_req = 1'b1; if_addr = 32'h40; mem_ack = 1'b0;
      #1 reset = 1'b0;
      busy = 1'b0; streak = 0;
      @(negedge clk);
      step();
      chk("post_rst_grant_addr", mem_addr, 32'h40);
    end

    p_raise_if = 30; p_raise_d = 30; p_keep = 50;
    run(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
